// File: rtl/id_ex_hazard_reg.sv
// ID/EX pipeline register with load-use / forwarding hazard detection.
// Registers decode operands and controls, forward selects fa/fb, and a saturating stall counter.
module id_ex_hazard_reg #(
  parameter int W  = 24,
  parameter int RA = 4,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          id_valid,
  input  logic [W-1:0]  id_rd1,
  input  logic [W-1:0]  id_rd2,
  input  logic [W-1:0]  id_imm,
  input  logic [W-1:0]  id_pc,
  input  logic [RA-1:0] id_rs1,
  input  logic [RA-1:0] id_rs2,
  input  logic          id_use_rs1,
  input  logic          id_use_rs2,
  input  logic [RA-1:0] id_rd,
  input  logic          id_reg_write,
  input  logic          id_mem_read,
  input  logic          id_imm_src,
  input  logic          id_branch,
  input  logic          exm_valid,
  input  logic          exm_reg_write,
  input  logic [RA-1:0] exm_rd,
  input  logic          flush,
  output logic          stall,
  output logic          ex_valid,
  output logic [W-1:0]  ex_rd1,
  output logic [W-1:0]  ex_rd2,
  output logic [W-1:0]  ex_imm,
  output logic [W-1:0]  ex_pc,
  output logic [RA-1:0] ex_rd,
  output logic          ex_reg_write,
  output logic          ex_mem_read,
  output logic          ex_imm_src,
  output logic          ex_branch,
  output logic          fa,
  output logic          fb,
  output logic [CW-1:0] stall_cnt
);

  logic          valid_q, valid_d;
  logic [W-1:0]  rd1_q, rd1_d, rd2_q, rd2_d, imm_q, imm_d, pc_q, pc_d;
  logic [RA-1:0] rd_q, rd_d;
  logic          regWrite_q, regWrite_d, memRead_q, memRead_d;
  logic          immSrc_q, immSrc_d, branch_q, branch_d;
  logic          fa_q, fa_d, fb_q, fb_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic p1Valid, p2Valid, rs1Chk, rs2Chk;
  logic p1Rs1, p2Rs1, p1Rs2, p2Rs2;
  logic hazard, bubble, faNext, fbNext;

  // P1 is the instruction now in EX; P2 is the one now in EX/MEM. P1 wins on rs1 matches.
  always_comb begin
    p1Valid = valid_q & regWrite_q & (rd_q != '0);
    p2Valid = exm_valid & exm_reg_write & (exm_rd != '0);
    rs1Chk  = id_valid & id_use_rs1 & (id_rs1 != '0);
    rs2Chk  = id_valid & id_use_rs2 & (id_rs2 != '0) & ~id_imm_src;
    p1Rs1   = rs1Chk & p1Valid & (rd_q == id_rs1);
    p2Rs1   = rs1Chk & p2Valid & (exm_rd == id_rs1) & ~p1Rs1;
    p1Rs2   = rs2Chk & p1Valid & (rd_q == id_rs2);
    p2Rs2   = rs2Chk & p2Valid & (exm_rd == id_rs2) & ~p1Rs2;
    hazard  = (p1Rs1 & (memRead_q | id_branch)) | (p2Rs1 & ~id_branch) | p1Rs2;
    faNext  = (p1Rs1 & ~memRead_q & ~id_branch) | (p2Rs1 & id_branch);
    fbNext  = p2Rs2;
    stall   = hazard & ~flush & ~rst;
    bubble  = flush | stall | ~id_valid;
  end

  always_comb begin
    valid_d    = 1'b0;
    regWrite_d = 1'b0;
    memRead_d  = 1'b0;
    fa_d       = 1'b0;
    fb_d       = 1'b0;
    rd1_d      = rd1_q;
    rd2_d      = rd2_q;
    imm_d      = imm_q;
    pc_d       = pc_q;
    rd_d       = rd_q;
    immSrc_d   = immSrc_q;
    branch_d   = branch_q;
    cnt_d      = cnt_q;
    if (!bubble) begin
      valid_d    = 1'b1;
      regWrite_d = id_reg_write;
      memRead_d  = id_mem_read;
      fa_d       = faNext;
      fb_d       = fbNext;
      rd1_d      = id_rd1;
      rd2_d      = id_rd2;
      imm_d      = id_imm;
      pc_d       = id_pc;
      rd_d       = id_rd;
      immSrc_d   = id_imm_src;
      branch_d   = id_branch;
    end
    if (stall && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q    <= 1'b0;
      regWrite_q <= 1'b0;
      memRead_q  <= 1'b0;
      fa_q       <= 1'b0;
      fb_q       <= 1'b0;
      rd1_q      <= '0;
      rd2_q      <= '0;
      imm_q      <= '0;
      pc_q       <= '0;
      rd_q       <= '0;
      immSrc_q   <= 1'b0;
      branch_q   <= 1'b0;
      cnt_q      <= '0;
    end else begin
      valid_q    <= valid_d;
      regWrite_q <= regWrite_d;
      memRead_q  <= memRead_d;
      fa_q       <= fa_d;
      fb_q       <= fb_d;
      rd1_q      <= rd1_d;
      rd2_q      <= rd2_d;
      imm_q      <= imm_d;
      pc_q       <= pc_d;
      rd_q       <= rd_d;
      immSrc_q   <= immSrc_d;
      branch_q   <= branch_d;
      cnt_q      <= cnt_d;
    end
  end

  assign ex_valid     = valid_q;
  assign ex_rd1       = rd1_q;
  assign ex_rd2       = rd2_q;
  assign ex_imm       = imm_q;
  assign ex_pc        = pc_q;
  assign ex_rd        = rd_q;
  assign ex_reg_write = regWrite_q;
  assign ex_mem_read  = memRead_q;
  assign ex_imm_src   = immSrc_q;
  assign ex_branch    = branch_q;
  assign fa           = fa_q;
  assign fb           = fb_q;
  assign stall_cnt    = cnt_q;

endmodule

// File: tb/tb_id_ex_hazard_reg.sv
// Self-checking bench for id_ex_hazard_reg: table-driven pipeline sequence with a
// scoreboard queue of next-cycle expectations, plus reset and saturation sequences.
module tb_id_ex_hazard_reg;
  localparam int W  = 24;
  localparam int RA = 4;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          id_valid;
  logic [W-1:0]  id_rd1, id_rd2, id_imm, id_pc;
  logic [RA-1:0] id_rs1, id_rs2, id_rd;
  logic          id_use_rs1, id_use_rs2, id_reg_write, id_mem_read, id_imm_src, id_branch;
  logic          exm_valid, exm_reg_write;
  logic [RA-1:0] exm_rd;
  logic          flush;
  logic          stall, ex_valid;
  logic [W-1:0]  ex_rd1, ex_rd2, ex_imm, ex_pc;
  logic [RA-1:0] ex_rd;
  logic          ex_reg_write, ex_mem_read, ex_imm_src, ex_branch, fa, fb;
  logic [CW-1:0] stall_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  id_ex_hazard_reg #(.W(W), .RA(RA), .CW(CW)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm(id_imm), .id_pc(id_pc),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .id_rd(id_rd), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .id_imm_src(id_imm_src), .id_branch(id_branch),
    .exm_valid(exm_valid), .exm_reg_write(exm_reg_write), .exm_rd(exm_rd),
    .flush(flush), .stall(stall), .ex_valid(ex_valid),
    .ex_rd1(ex_rd1), .ex_rd2(ex_rd2), .ex_imm(ex_imm), .ex_pc(ex_pc), .ex_rd(ex_rd),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_imm_src(ex_imm_src),
    .ex_branch(ex_branch), .fa(fa), .fb(fb), .stall_cnt(stall_cnt)
  );

  typedef struct {
    logic rst, flush, v;
    logic [RA-1:0] rs1; logic u1;
    logic [RA-1:0] rs2; logic u2;
    logic [RA-1:0] rd; logic rw, mr, imm, br;
    logic xv, xrw; logic [RA-1:0] xrd;
    logic eStall, eValid, eFa, eFb; int eCnt;
  } vec_t;

  typedef struct {
    int tag;
    logic chkData, valid, fa, fb; int cnt;
    logic [W-1:0] rd1, rd2, imm, pc;
    logic [RA-1:0] rd; logic rw, mr, immSrc, br;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  function automatic vec_t mk(input logic r, fl, v, input int rs1, input logic u1,
                              input int rs2, input logic u2, input int rd,
                              input logic rw, mr, imm, br, xv, xrw, input int xrd,
                              input logic es, ev, efa, efb, input int ecnt);
    vec_t t;
    t.rst = r; t.flush = fl; t.v = v;
    t.rs1 = RA'(rs1); t.u1 = u1; t.rs2 = RA'(rs2); t.u2 = u2;
    t.rd = RA'(rd); t.rw = rw; t.mr = mr; t.imm = imm; t.br = br;
    t.xv = xv; t.xrw = xrw; t.xrd = RA'(xrd);
    t.eStall = es; t.eValid = ev; t.eFa = efa; t.eFb = efb; t.eCnt = ecnt;
    return t;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t t);
    rst = t.rst; flush = t.flush; id_valid = t.v;
    id_rs1 = t.rs1; id_use_rs1 = t.u1; id_rs2 = t.rs2; id_use_rs2 = t.u2;
    id_rd = t.rd; id_reg_write = t.rw; id_mem_read = t.mr;
    id_imm_src = t.imm; id_branch = t.br;
    exm_valid = t.xv; exm_reg_write = t.xrw; exm_rd = t.xrd;
    id_rd1 = W'($urandom); id_rd2 = W'($urandom);
    id_imm = W'($urandom); id_pc = W'($urandom);
  endtask

  task automatic checkPopped(input exp_t e);
    string p;
    p = $sformatf("row%0d", e.tag);
    checkOutput({p, " ex_valid"}, 32'(ex_valid), 32'(e.valid));
    checkOutput({p, " fa"}, 32'(fa), 32'(e.fa));
    checkOutput({p, " fb"}, 32'(fb), 32'(e.fb));
    checkOutput({p, " stall_cnt"}, 32'(stall_cnt), 32'(e.cnt));
    if (!e.valid) begin
      checkOutput({p, " ex_reg_write bubble"}, 32'(ex_reg_write), 32'(0));
      checkOutput({p, " ex_mem_read bubble"}, 32'(ex_mem_read), 32'(0));
    end
    if (e.chkData) begin
      checkOutput({p, " ex_rd1"}, 32'(ex_rd1), 32'(e.rd1));
      checkOutput({p, " ex_rd2"}, 32'(ex_rd2), 32'(e.rd2));
      checkOutput({p, " ex_imm"}, 32'(ex_imm), 32'(e.imm));
      checkOutput({p, " ex_pc"}, 32'(ex_pc), 32'(e.pc));
      checkOutput({p, " ex_rd"}, 32'(ex_rd), 32'(e.rd));
      checkOutput({p, " ex_reg_write"}, 32'(ex_reg_write), 32'(e.rw));
      checkOutput({p, " ex_mem_read"}, 32'(ex_mem_read), 32'(e.mr));
      checkOutput({p, " ex_imm_src"}, 32'(ex_imm_src), 32'(e.immSrc));
      checkOutput({p, " ex_branch"}, 32'(ex_branch), 32'(e.br));
    end
  endtask

  initial begin
    exp_t e;
    // rst,fl,v, rs1,u1, rs2,u2, rd,rw,mr,imm,br, xv,xrw,xrd, stall,valid,fa,fb,cnt
    vecs.push_back(mk(0,0,1, 1,1, 2,1,  3,1,0,0,0, 0,0,0,  0,1,0,0,0));
    vecs.push_back(mk(0,0,1, 3,1, 6,1,  7,1,0,0,0, 0,0,0,  0,1,1,0,0));
    vecs.push_back(mk(0,0,1, 0,0, 0,0,  5,1,1,0,0, 1,1,3,  0,1,0,0,0));
    vecs.push_back(mk(0,0,1, 5,1, 0,0,  8,1,0,0,0, 1,1,7,  1,0,0,0,1));
    vecs.push_back(mk(0,0,1, 5,1, 0,0,  8,1,0,0,0, 1,1,5,  1,0,0,0,2));
    vecs.push_back(mk(0,0,1, 5,1, 0,0,  8,1,0,0,0, 0,0,0,  0,1,0,0,2));
    vecs.push_back(mk(0,0,1, 0,0, 0,0,  2,1,0,0,0, 0,0,0,  0,1,0,0,2));
    vecs.push_back(mk(0,0,1, 2,1, 9,1,  0,0,0,0,1, 1,1,8,  1,0,0,0,3));
    vecs.push_back(mk(0,0,1, 2,1, 9,1,  0,0,0,0,1, 1,1,2,  0,1,1,0,3));
    vecs.push_back(mk(0,0,1, 0,0, 4,1, 10,1,0,1,0, 1,1,4,  0,1,0,0,3));
    vecs.push_back(mk(0,0,1, 0,0, 4,1, 11,1,0,0,0, 1,1,4,  0,1,0,1,3));
    vecs.push_back(mk(0,0,1, 0,0,11,1, 12,1,0,0,0, 0,0,0,  1,0,0,0,4));
    vecs.push_back(mk(0,0,1, 0,0, 0,0,  5,1,1,0,0, 0,0,0,  0,1,0,0,4));
    vecs.push_back(mk(0,1,1, 5,1, 0,0,  8,1,0,0,0, 0,0,0,  0,0,0,0,4));
    vecs.push_back(mk(0,0,1, 0,1, 0,0,  0,1,0,0,0, 1,1,0,  0,1,0,0,4));
    vecs.push_back(mk(0,0,1, 0,1, 0,1,  5,1,0,0,0, 1,1,0,  0,1,0,0,4));
    vecs.push_back(mk(0,0,0, 5,1, 0,0,  0,0,0,0,0, 0,0,0,  0,0,0,0,4));
    vecs.push_back(mk(0,0,1, 0,0, 0,0,  6,1,1,0,0, 0,0,0,  0,1,0,0,4));
    vecs.push_back(mk(0,0,1, 6,1, 0,0, 12,1,0,0,0, 0,0,0,  1,0,0,0,5));
    vecs.push_back(mk(1,0,1, 6,1, 0,0, 12,1,0,0,0, 1,1,6,  0,0,0,0,0));
    vecs.push_back(mk(0,0,1, 6,1, 0,0, 12,1,0,0,0, 0,0,0,  0,1,0,0,0));
    vecs.push_back(mk(0,0,1,12,1, 0,0, 13,1,0,0,0, 1,1,12, 0,1,1,0,0));

    // Two reset cycles with random inputs.
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      applyStimulus(mk(1, 1'($urandom), 1'($urandom), int'($urandom_range(15)), 1'($urandom),
                       int'($urandom_range(15)), 1'($urandom), int'($urandom_range(15)),
                       1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                       1'($urandom), 1'($urandom), int'($urandom_range(15)), 0,0,0,0,0));
      #1 checkOutput("reset stall", 32'(stall), 32'(0));
      @(posedge clk); #1;
      checkOutput("reset ex_valid", 32'(ex_valid), 32'(0));
      checkOutput("reset outputs", {ex_rd1, ex_rd[3:0], 4'b0}, 32'(0));
      checkOutput("reset ctrl", {24'(0), ex_reg_write, ex_mem_read, ex_imm_src, ex_branch,
                                 fa, fb, 2'b0}, 32'(0));
      checkOutput("reset data", 32'(ex_rd2 | ex_imm | ex_pc), 32'(0));
      checkOutput("reset stall_cnt", 32'(stall_cnt), 32'(0));
    end

    foreach (vecs[i]) begin
      @(negedge clk);
      applyStimulus(vecs[i]);
      #1 checkOutput($sformatf("row%0d stall", i), 32'(stall), 32'(vecs[i].eStall));
      e.tag = i; e.valid = vecs[i].eValid; e.fa = vecs[i].eFa; e.fb = vecs[i].eFb;
      e.cnt = vecs[i].eCnt; e.chkData = vecs[i].eValid | vecs[i].rst;
      e.rd1 = vecs[i].rst ? '0 : id_rd1; e.rd2 = vecs[i].rst ? '0 : id_rd2;
      e.imm = vecs[i].rst ? '0 : id_imm; e.pc = vecs[i].rst ? '0 : id_pc;
      e.rd = vecs[i].rst ? '0 : vecs[i].rd; e.rw = vecs[i].rst ? 1'b0 : vecs[i].rw;
      e.mr = vecs[i].rst ? 1'b0 : vecs[i].mr; e.immSrc = vecs[i].rst ? 1'b0 : vecs[i].imm;
      e.br = vecs[i].rst ? 1'b0 : vecs[i].br;
      sb.push_back(e);
      @(posedge clk); #1;
      if (sb.size() == 0) begin
        checkOutput("scoreboard empty", 32'(0), 32'(1));
      end else begin
        checkPopped(sb.pop_front());
      end
    end

    // Saturation: hold a P2 hazard so stall stays high for 2^CW+3 cycles.
    @(negedge clk);
    applyStimulus(mk(1,0,0, 0,0, 0,0, 0,0,0,0,0, 0,0,0, 0,0,0,0,0));
    @(negedge clk);
    applyStimulus(mk(0,0,1, 5,1, 0,0, 8,1,0,0,0, 1,1,5, 1,0,0,0,0));
    #1 checkOutput("sat stall", 32'(stall), 32'(1));
    for (int n = 1; n <= (1 << CW) + 3; n++) begin
      @(posedge clk); #1;
      if (n == (1 << CW) - 2) checkOutput("sat below max", 32'(stall_cnt), 32'((1 << CW) - 2));
      if (n == (1 << CW) - 1) checkOutput("sat reach max", 32'(stall_cnt), 32'((1 << CW) - 1));
    end
    checkOutput("sat hold max", 32'(stall_cnt), 32'((1 << CW) - 1));
    checkOutput("sat ex_valid", 32'(ex_valid), 32'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
